// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with register file, immediate
// extension, load-use hazard detection and a registered EX pipeline register.
module id_stage_pipe #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      instruction,
  input  logic             rb_selector,
  input  logic [1:0]       ext_selector,
  input  logic             we,
  input  logic [RA_W-1:0]  rw,
  input  logic [WIDTH-1:0] wd,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [2:0]       ex_op,
  output logic [1:0]       ex_func,
  output logic [RA_W-1:0]  ex_rf,
  output logic [RA_W-1:0]  ex_ra,
  output logic [RA_W-1:0]  ex_rb,
  output logic [WIDTH-1:0] ex_rda,
  output logic [WIDTH-1:0] ex_rdb,
  output logic [WIDTH-1:0] ex_ext
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDR = 3'b010;
  localparam logic [2:0] OP_STR = 3'b011;

  logic [WIDTH-1:0] regs_r [NREGS];

  logic [2:0]       op_s;
  logic [1:0]       func_s;
  logic [RA_W-1:0]  rf_s;
  logic [RA_W-1:0]  ra_s;
  logic [RA_W-1:0]  rb_s;
  logic [WIDTH-1:0] rda_s;
  logic [WIDTH-1:0] rdb_s;
  logic [WIDTH-1:0] ext_s;
  logic             uses_rb_s;
  logic             hazard_s;
  logic             bubble_s;

  // Immediate extension; the size cast sign- or zero-extends according to the
  // signedness of the selected field and truncates for narrow datapaths.
  function automatic logic [WIDTH-1:0] ext_imm(input logic [31:0] inst,
                                               input logic [1:0]  sel);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = WIDTH'(inst[13:2]);
      2'b01:   r = WIDTH'($signed(inst[13:0]));
      2'b10:   r = WIDTH'($signed(inst[28:0]));
      2'b11:   r = {WIDTH{1'b0}};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign op_s   = instruction[31:29];
  assign func_s = instruction[1:0];
  assign rf_s   = instruction[24 +: RA_W];
  assign ra_s   = instruction[19 +: RA_W];
  assign ext_s  = ext_imm(instruction, ext_selector);

  // Select the rb field: normal second source, or rf slot for store data.
  always_comb begin
    if (rb_selector) rb_s = instruction[24 +: RA_W];
    else             rb_s = instruction[14 +: RA_W];
  end

  // Port A read with write-through of the same-cycle WB write.
  always_comb begin
    if (we && (rw == ra_s)) rda_s = wd;
    else                    rda_s = regs_r[ra_s];
  end

  // Port B read with write-through of the same-cycle WB write.
  always_comb begin
    if (we && (rw == rb_s)) rdb_s = wd;
    else                    rdb_s = regs_r[rb_s];
  end

  // Ops whose rb field is a real source operand for hazard purposes.
  always_comb begin
    case (op_s)
      OP_ADD, OP_SUB, OP_STR: uses_rb_s = 1'b1;
      default:                uses_rb_s = 1'b0;
    endcase
  end

  // Load-use hazard: uses EX state and the current decode only (never we/wd).
  assign hazard_s = ex_valid && (ex_op == OP_LDR) && in_valid &&
                    ((ex_rf == ra_s) || (uses_rb_s && (ex_rf == rb_s)));
  assign stall    = hazard_s && !flush && reset;
  assign bubble_s = flush || hazard_s || !in_valid;

  // Register file write port; every register, R0 included, is writable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {WIDTH{1'b0}};
    end else if (we) begin
      regs_r[rw] <= wd;
    end
  end

  // EX pipeline register: load decoded instruction or a zeroed bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bubble_s) begin
      ex_valid <= 1'b0;
      ex_op    <= 3'b000;
      ex_func  <= 2'b00;
      ex_rf    <= {RA_W{1'b0}};
      ex_ra    <= {RA_W{1'b0}};
      ex_rb    <= {RA_W{1'b0}};
      ex_rda   <= {WIDTH{1'b0}};
      ex_rdb   <= {WIDTH{1'b0}};
      ex_ext   <= {WIDTH{1'b0}};
    end else begin
      ex_valid <= 1'b1;
      ex_op    <= op_s;
      ex_func  <= func_s;
      ex_rf    <= rf_s;
      ex_ra    <= ra_s;
      ex_rb    <= rb_s;
      ex_rda   <= rda_s;
      ex_rdb   <= rdb_s;
      ex_ext   <= ext_s;
    end
  end

endmodule
